// File: rtl/id_exe_reg_if.sv
// ID->EXE slot bundle: the ID-side *_in fields and the registered EXE-side *_out copies.
interface id_exe_reg_if #(
  parameter int n = 32
);
  logic         valid_in;
  logic [n-1:0] PC_in;
  logic [3:0]   EXE_CMD_in;
  logic         S_in;
  logic         B_in;
  logic         MEM_W_EN_in;
  logic         MEM_R_EN_in;
  logic         WB_EN_in;
  logic         imm_in;
  logic [11:0]  Shift_operand_in;
  logic [23:0]  Signed_imm_24_in;
  logic [n-1:0] Val_Rn_in;
  logic [n-1:0] Val_Rm_in;
  logic [3:0]   Dest_in;
  logic [3:0]   src1_in;
  logic [3:0]   src2_in;
  logic         C_in;

  logic         valid_out;
  logic [n-1:0] PC_out;
  logic [3:0]   EXE_CMD_out;
  logic         S_out;
  logic         B_out;
  logic         MEM_W_EN_out;
  logic         MEM_R_EN_out;
  logic         WB_EN_out;
  logic         imm_out;
  logic [11:0]  Shift_operand_out;
  logic [23:0]  Signed_imm_24_out;
  logic [n-1:0] Val_Rn_out;
  logic [n-1:0] Val_Rm_out;
  logic [3:0]   Dest_out;
  logic [3:0]   src1_out;
  logic [3:0]   src2_out;
  logic         C_out;

  modport master (
    output valid_in, PC_in, EXE_CMD_in, S_in, B_in,
           MEM_W_EN_in, MEM_R_EN_in, WB_EN_in, imm_in,
           Shift_operand_in, Signed_imm_24_in,
           Val_Rn_in, Val_Rm_in, Dest_in,
           src1_in, src2_in, C_in,
    input  valid_out, PC_out, EXE_CMD_out, S_out, B_out,
           MEM_W_EN_out, MEM_R_EN_out, WB_EN_out, imm_out,
           Shift_operand_out, Signed_imm_24_out,
           Val_Rn_out, Val_Rm_out, Dest_out,
           src1_out, src2_out, C_out
  );

  modport slave (
    input  valid_in, PC_in, EXE_CMD_in, S_in, B_in,
           MEM_W_EN_in, MEM_R_EN_in, WB_EN_in, imm_in,
           Shift_operand_in, Signed_imm_24_in,
           Val_Rn_in, Val_Rm_in, Dest_in,
           src1_in, src2_in, C_in,
    output valid_out, PC_out, EXE_CMD_out, S_out, B_out,
           MEM_W_EN_out, MEM_R_EN_out, WB_EN_out, imm_out,
           Shift_operand_out, Signed_imm_24_out,
           Val_Rn_out, Val_Rm_out, Dest_out,
           src1_out, src2_out, C_out
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register with freeze (stall), flush (bubble) and
// saturating stall/flush cycle counters.
module id_exe_reg #(
  parameter int n     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  id_exe_reg_if.slave      bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic         valid;
    logic [n-1:0] pc;
    logic [3:0]   cmd;
    logic         s;
    logic         b;
    logic         mem_w;
    logic         mem_r;
    logic         wb;
    logic         imm;
    logic [11:0]  shop;
    logic [23:0]  simm;
    logic [n-1:0] rn;
    logic [n-1:0] rm;
    logic [3:0]   dest;
    logic [3:0]   src1;
    logic [3:0]   src2;
    logic         c;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  slot_t            w_in;
  slot_t            r_slot;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_in = {
    bus.valid_in, bus.PC_in, bus.EXE_CMD_in,
    bus.S_in, bus.B_in,
    bus.MEM_W_EN_in, bus.MEM_R_EN_in,
    bus.WB_EN_in, bus.imm_in,
    bus.Shift_operand_in, bus.Signed_imm_24_in,
    bus.Val_Rn_in, bus.Val_Rm_in,
    bus.Dest_in, bus.src1_in, bus.src2_in,
    bus.C_in
  };

  // A flush under freeze is dropped; the branch re-asserts it after.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (freeze) begin
      if (r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else if (flush) begin
      r_slot <= '0;
      if (r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end else begin
      r_slot <= w_in;
    end
  end

  assign {
    bus.valid_out, bus.PC_out, bus.EXE_CMD_out,
    bus.S_out, bus.B_out,
    bus.MEM_W_EN_out, bus.MEM_R_EN_out,
    bus.WB_EN_out, bus.imm_out,
    bus.Shift_operand_out, bus.Signed_imm_24_out,
    bus.Val_Rn_out, bus.Val_Rm_out,
    bus.Dest_out, bus.src1_out, bus.src2_out,
    bus.C_out
  } = r_slot;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
